// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan_decoder slice: mode encodings and FSM state type.
package scan_decoder_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_PULSE,
    ST_SCAN
  } state_t;

endpackage

// File: rtl/scan_decoder_core.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable, built recursively:
// the MSB splits the enable between two half-width decoders; SEL_W=1 is the leaf.
module decoder_core #(
  parameter int SEL_W = 3
) (
  input  logic                  i_en,
  input  logic [SEL_W-1:0]      i_sel,
  output logic [2**SEL_W-1:0]   o_onehot
);

  generate
    if (SEL_W == 1) begin : g_leaf
      assign o_onehot = {i_en & i_sel[0], i_en & ~i_sel[0]};
    end else begin : g_split
      logic w_en_lo;
      logic w_en_hi;

      assign w_en_hi = i_en &  i_sel[SEL_W-1];
      assign w_en_lo = i_en & ~i_sel[SEL_W-1];

      decoder_core #(.SEL_W(SEL_W-1)) u_lo (
        .i_en     (w_en_lo),
        .i_sel    (i_sel[SEL_W-2:0]),
        .o_onehot (o_onehot[2**(SEL_W-1)-1:0])
      );

      decoder_core #(.SEL_W(SEL_W-1)) u_hi (
        .i_en     (w_en_hi),
        .i_sel    (i_sel[SEL_W-2:0]),
        .o_onehot (o_onehot[2**SEL_W-1:2**(SEL_W-1)])
      );
    end
  endgenerate

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-hold, one-shot pulse and free-running scan modes.
// Holds the FSM, dwell/pulse counters and the y/cur_sel output registers.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int DWELL     = 4,
  parameter int PULSE_LEN = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_valid,
  output logic                sel_ready,
  output logic [2**SEL_W-1:0] y,
  output logic [SEL_W-1:0]    cur_sel,
  output logic                busy,
  output logic                wrap
);

  localparam int N    = 2**SEL_W;
  localparam int CW_D = $clog2(DWELL + 1);
  localparam int CW_P = $clog2(PULSE_LEN + 1);
  localparam logic [CW_D-1:0] DWELL_LAST = CW_D'(DWELL - 1);
  localparam logic [CW_P-1:0] PULSE_LAST = CW_P'(PULSE_LEN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_mode_prev;
  logic [SEL_W-1:0]  r_cur_sel;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [CW_D-1:0]   r_dwell;
  logic [CW_D-1:0]   w_dwell_nxt;
  logic [CW_P-1:0]   r_pulse;
  logic [CW_P-1:0]   w_pulse_nxt;
  logic              r_wrap;
  logic              w_wrap_nxt;
  logic [N-1:0]      r_y;
  logic [N-1:0]      w_y_nxt;
  logic              w_y_on;
  logic              w_mode_chg;
  logic              w_accept;
  logic              w_resume;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode_prev <= mode;
      r_cur_sel   <= '0;
      r_dwell     <= '0;
      r_pulse     <= '0;
      r_wrap      <= 1'b0;
      r_y         <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_prev <= mode;
      r_cur_sel   <= w_sel_nxt;
      r_dwell     <= w_dwell_nxt;
      r_pulse     <= w_pulse_nxt;
      r_wrap      <= w_wrap_nxt;
      r_y         <= w_y_nxt;
    end
  end

  // An active state with y cleared means en just returned: re-drive y without counting.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_cur_sel;
    w_dwell_nxt = r_dwell;
    w_pulse_nxt = r_pulse;
    w_wrap_nxt  = 1'b0;
    w_y_on      = 1'b0;
    w_resume    = (r_y == '0);
    if (w_mode_chg) begin
      w_state_nxt = ST_IDLE;
      w_dwell_nxt = '0;
      w_pulse_nxt = '0;
    end else if (en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && mode == MODE_DIRECT) begin
            w_state_nxt = ST_HOLD;
            w_sel_nxt   = sel;
            w_y_on      = 1'b1;
          end else if (w_accept && mode == MODE_PULSE) begin
            w_state_nxt = ST_PULSE;
            w_sel_nxt   = sel;
            w_pulse_nxt = '0;
            w_y_on      = 1'b1;
          end else if (mode == MODE_SCAN) begin
            w_state_nxt = ST_SCAN;
            w_sel_nxt   = '0;
            w_dwell_nxt = '0;
            w_y_on      = 1'b1;
          end
        end
        ST_HOLD: begin
          w_y_on = 1'b1;
          if (w_accept) w_sel_nxt = sel;
        end
        ST_PULSE: begin
          w_y_on = 1'b1;
          if (!w_resume) begin
            if (r_pulse == PULSE_LAST) begin
              w_state_nxt = ST_IDLE;
              w_pulse_nxt = '0;
              w_y_on      = 1'b0;
            end else begin
              w_pulse_nxt = r_pulse + 1'b1;
            end
          end
        end
        ST_SCAN: begin
          w_y_on = 1'b1;
          if (!w_resume) begin
            if (r_dwell == DWELL_LAST) begin
              w_dwell_nxt = '0;
              w_sel_nxt   = r_cur_sel + 1'b1;
              w_wrap_nxt  = (r_cur_sel == '1);
            end else begin
              w_dwell_nxt = r_dwell + 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_mode_chg = (mode != r_mode_prev);
    sel_ready  = 1'b0;
    if (en && !w_mode_chg) begin
      if (mode == MODE_DIRECT)
        sel_ready = (r_state == ST_IDLE) || (r_state == ST_HOLD);
      else if (mode == MODE_PULSE)
        sel_ready = (r_state == ST_IDLE);
    end
    w_accept = sel_valid && sel_ready;
    busy     = (r_state == ST_PULSE) || (r_state == ST_SCAN);
  end

  decoder_core #(.SEL_W(SEL_W)) u_core (
    .i_en     (w_y_on),
    .i_sel    (w_sel_nxt),
    .o_onehot (w_y_nxt)
  );

  assign y       = r_y;
  assign cur_sel = r_cur_sel;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: directed scenarios on the 3-bit build plus randomized traffic
// on 3-, 1- and 4-bit builds checked against a behavioural model.
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, sel_valid;
  logic [1:0] mode;
  logic [5:0] sel;

  logic [7:0]  y0;  logic [2:0] cs0; logic busy0, wrap0, rdy0;
  logic [1:0]  y1;  logic [0:0] cs1; logic busy1, wrap1, rdy1;
  logic [15:0] y2;  logic [3:0] cs2; logic busy2, wrap2, rdy2;

  scan_decoder #(.SEL_W(3), .DWELL(4), .PULSE_LEN(2)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[2:0]), .sel_valid(sel_valid),
    .sel_ready(rdy0), .y(y0), .cur_sel(cs0), .busy(busy0), .wrap(wrap0));
  scan_decoder #(.SEL_W(1), .DWELL(1), .PULSE_LEN(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[0:0]), .sel_valid(sel_valid),
    .sel_ready(rdy1), .y(y1), .cur_sel(cs1), .busy(busy1), .wrap(wrap1));
  scan_decoder #(.SEL_W(4), .DWELL(3), .PULSE_LEN(3)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[3:0]), .sel_valid(sel_valid),
    .sel_ready(rdy2), .y(y2), .cur_sel(cs2), .busy(busy2), .wrap(wrap2));

  logic [63:0] dy [3];
  logic [5:0]  dcs[3];
  logic        dbusy[3], dwrap[3], drdy[3];
  assign dy[0] = 64'(y0);  assign dcs[0] = 6'(cs0); assign dbusy[0] = busy0; assign dwrap[0] = wrap0; assign drdy[0] = rdy0;
  assign dy[1] = 64'(y1);  assign dcs[1] = 6'(cs1); assign dbusy[1] = busy1; assign dwrap[1] = wrap1; assign drdy[1] = rdy1;
  assign dy[2] = 64'(y2);  assign dcs[2] = 6'(cs2); assign dbusy[2] = busy2; assign dwrap[2] = wrap2; assign drdy[2] = rdy2;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_HOLD = 1, PH_PULSE = 2, PH_SCAN = 3;
  int P_SW[3] = '{3, 1, 4};
  int P_DW[3] = '{4, 1, 3};
  int P_PL[3] = '{2, 1, 3};
  int         m_phase[3];
  int         m_left[3];
  int         m_sel[3];
  bit         m_on[3];
  bit         m_wrap[3];
  logic [1:0] m_prev[3];

  function automatic bit m_ready(input int k);
    if (!en || mode != m_prev[k]) return 1'b0;
    if (mode == 2'b00) return (m_phase[k] == PH_IDLE || m_phase[k] == PH_HOLD);
    if (mode == 2'b10) return (m_phase[k] == PH_IDLE);
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_y(input int k);
    return m_on[k] ? (64'd1 << m_sel[k]) : 64'd0;
  endfunction

  task automatic model_step(input int k);
    int  n;
    int  s;
    bit  acc;
    bit  chg;
    n   = 1 << P_SW[k];
    s   = int'(sel) % n;
    acc = sel_valid && m_ready(k);
    chg = (mode != m_prev[k]);
    m_wrap[k] = 1'b0;
    if (rst) begin
      m_phase[k] = PH_IDLE; m_sel[k] = 0; m_on[k] = 1'b0; m_left[k] = 0; m_prev[k] = mode;
      return;
    end
    m_prev[k] = mode;
    if (chg) begin
      m_phase[k] = PH_IDLE; m_on[k] = 1'b0; m_left[k] = 0;
      return;
    end
    if (!en) begin
      m_on[k] = 1'b0;
      return;
    end
    case (m_phase[k])
      PH_IDLE: begin
        m_on[k] = 1'b0;
        if (mode == 2'b00 && acc) begin
          m_phase[k] = PH_HOLD; m_sel[k] = s; m_on[k] = 1'b1;
        end else if (mode == 2'b10 && acc) begin
          m_phase[k] = PH_PULSE; m_sel[k] = s; m_on[k] = 1'b1; m_left[k] = P_PL[k];
        end else if (mode == 2'b01) begin
          m_phase[k] = PH_SCAN; m_sel[k] = 0; m_on[k] = 1'b1; m_left[k] = P_DW[k];
        end
      end
      PH_HOLD: begin
        if (acc) m_sel[k] = s;
        m_on[k] = 1'b1;
      end
      PH_PULSE: begin
        if (!m_on[k]) m_on[k] = 1'b1;
        else begin
          m_left[k]--;
          if (m_left[k] == 0) begin m_phase[k] = PH_IDLE; m_on[k] = 1'b0; end
        end
      end
      default: begin
        if (!m_on[k]) m_on[k] = 1'b1;
        else begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_sel[k]  = (m_sel[k] + 1) % n;
            m_left[k] = P_DW[k];
            m_wrap[k] = (m_sel[k] == 0);
          end
        end
      end
    endcase
  endtask

  always @(posedge clk) for (int k = 0; k < 3; k++) model_step(k);

  always @(negedge clk) begin
    total++;
    if (!$onehot0(y0) || !$onehot0(y1) || !$onehot0(y2)) begin
      bad++;
      $display("FAIL onehot t=%0t y0=%h y1=%h y2=%h required one-hot or zero", $time, y0, y1, y2);
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1; en = 1'b1; mode = 2'b00; sel = '0; sel_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (y0 !== 8'h00 || cs0 !== 3'd0 || busy0 !== 1'b0 || wrap0 !== 1'b0 || rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL reset y=%h cs=%0d busy=%b wrap=%b rdy=%b required 00/0/0/0/1", y0, cs0, busy0, wrap0, rdy0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_direct;
    sel = 6'd5; sel_valid = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0;
    total++;
    if (y0 !== 8'b0010_0000) begin bad++; $display("FAIL direct_sel5 y=%h required 20", y0); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (y0 !== 8'h20 || cs0 !== 3'd5) begin
        bad++; $display("FAIL direct_hold i=%0d y=%h cs=%0d required 20/5", i, y0, cs0);
      end
    end
    sel = 6'd0; sel_valid = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0;
    total++;
    if (y0 !== 8'h01) begin bad++; $display("FAIL direct_sel0 y=%h required 01", y0); end
  endtask

  task automatic test_pulse;
    mode = 2'b10;
    @(negedge clk);
    total++;
    if (y0 !== 8'h00 || busy0 !== 1'b0) begin bad++; $display("FAIL pulse_abort y=%h busy=%b required 00/0", y0, busy0); end
    sel = 6'd2; sel_valid = 1'b1;
    #1;
    total++;
    if (rdy0 !== 1'b1) begin bad++; $display("FAIL pulse_ready_idle rdy=%b required 1", rdy0); end
    @(negedge clk);
    sel = 6'd7;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (y0 !== 8'h04 || busy0 !== 1'b1 || rdy0 !== 1'b0) begin
        bad++; $display("FAIL pulse_on i=%0d y=%h busy=%b rdy=%b required 04/1/0", i, y0, busy0, rdy0);
      end
      @(negedge clk);
    end
    sel_valid = 1'b0;
    total++;
    if (y0 !== 8'h00 || busy0 !== 1'b0 || cs0 !== 3'd2) begin
      bad++; $display("FAIL pulse_end y=%h busy=%b cs=%0d required 00/0/2", y0, busy0, cs0);
    end
  endtask

  task automatic test_scan;
    logic [7:0] ey;
    logic [2:0] ecs;
    mode = 2'b01;
    @(negedge clk);
    total++;
    if (y0 !== 8'h00) begin bad++; $display("FAIL scan_abort y=%h required 00", y0); end
    @(negedge clk);
    for (int c = 0; c < 36; c++) begin
      if (c > 0) @(negedge clk);
      ecs = 3'((c / 4) % 8);
      ey  = 8'd1 << ecs;
      total++;
      if (y0 !== ey || cs0 !== ecs || wrap0 !== (c == 32) || busy0 !== 1'b1) begin
        bad++; $display("FAIL scan c=%0d y=%h cs=%0d wrap=%b required %h/%0d/%b", c, y0, cs0, wrap0, ey, ecs, c == 32);
      end
    end
  endtask

  task automatic test_enable;
    logic [7:0] ey;
    mode = 2'b11;
    @(negedge clk);
    mode = 2'b01;
    @(negedge clk);
    @(negedge clk);
    repeat (13) @(negedge clk);
    total++;
    if (y0 !== 8'h08) begin bad++; $display("FAIL en_pre y=%h required 08", y0); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (y0 !== 8'h00 || cs0 !== 3'd3) begin
        bad++; $display("FAIL en_low i=%0d y=%h cs=%0d required 00/3", i, y0, cs0);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ey = (i < 3) ? 8'h08 : 8'h10;
      total++;
      if (y0 !== ey) begin bad++; $display("FAIL en_resume i=%0d y=%h required %h", i, y0, ey); end
    end
  endtask

  task automatic test_reset_mid_pulse;
    mode = 2'b10;
    @(negedge clk);
    sel = 6'd5; sel_valid = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0;
    total++;
    if (y0 !== 8'h20) begin bad++; $display("FAIL rstp_on y=%h required 20", y0); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (y0 !== 8'h00 || busy0 !== 1'b0 || rdy0 !== 1'b1 || cs0 !== 3'd0) begin
      bad++; $display("FAIL rstp y=%h busy=%b rdy=%b cs=%0d required 00/0/1/0", y0, busy0, rdy0, cs0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode_change;
    mode = 2'b01;
    repeat (7) @(negedge clk);
    total++;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL mc_scanning busy=%b required 1", busy0); end
    mode = 2'b00;
    @(negedge clk);
    total++;
    if (y0 !== 8'h00 || busy0 !== 1'b0) begin bad++; $display("FAIL mc_abort y=%h busy=%b required 00/0", y0, busy0); end
    sel = 6'd6; sel_valid = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0;
    total++;
    if (y0 !== 8'h40) begin bad++; $display("FAIL mc_direct y=%h required 40", y0); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (dy[k] !== m_y(k) || dcs[k] !== 6'(m_sel[k]) || dbusy[k] !== (m_phase[k] >= PH_PULSE) ||
            dwrap[k] !== m_wrap[k] || drdy[k] !== m_ready(k)) begin
          bad++;
          $display("FAIL rand k=%0d c=%0d y=%h cs=%0d busy=%b wrap=%b rdy=%b required %h/%0d/%b/%b/%b",
                   k, c, dy[k], dcs[k], dbusy[k], dwrap[k], drdy[k],
                   m_y(k), m_sel[k], m_phase[k] >= PH_PULSE, m_wrap[k], m_ready(k));
        end
      end
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      en        = ($urandom_range(0, 7) != 0);
      sel_valid = ($urandom_range(0, 2) == 0);
      sel       = 6'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_pulse();
    test_scan();
    test_enable();
    test_reset_mid_pulse();
    test_mode_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
